// File: rtl/fir_pkg.sv
// ============================================================================
//  Module   : fir_pkg
//  Brief    : Constants shared by the FIR engine and its output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

    localparam int FIR_DATA_WIDTH = 32;

    // A FIFO entry carries the sample plus its tlast flag in the MSB.
    function automatic int fir_entry_width(input int data_width);
        return data_width + 1;
    endfunction

    localparam int FIR_ENTRY_WIDTH = fir_entry_width(FIR_DATA_WIDTH);

endpackage

`default_nettype wire

// File: rtl/fir_fifo_ram.sv
// ============================================================================
//  Module   : fir_fifo_ram
//  Brief    : Register-array storage with one write port and an async read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_fifo_ram #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 33,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    // Contents are deliberately not reset; occupancy tracking makes them don't-care.
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fir_out_fifo.sv
// ============================================================================
//  Module   : fir_out_fifo
//  Brief    : FWFT AXI-Stream output FIFO for the FIR engine with frame counter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int pDEPTH      = 8,
    parameter int pCNT_WIDTH  = 16
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst_n,
    input  logic                       s_tvalid,
    input  logic [pDATA_WIDTH-1:0]     s_tdata,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic                       m_tvalid,
    output logic [pDATA_WIDTH-1:0]     m_tdata,
    output logic                       m_tlast,
    input  logic                       m_tready,
    output logic [$clog2(pDEPTH):0]    level,
    output logic                       frame_done,
    output logic [pCNT_WIDTH-1:0]      frame_cnt,
    input  logic                       cnt_clr
);

    localparam int c_ADDR_W  = $clog2(pDEPTH);
    localparam int c_CNT_W   = c_ADDR_W + 1;
    localparam int c_ENTRY_W = fir_entry_width(pDATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(pDEPTH);

    logic [c_ADDR_W-1:0]   r_wr_ptr;
    logic [c_ADDR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_frame_done;
    logic [pCNT_WIDTH-1:0] r_frame_cnt;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_last;
    logic [c_ENTRY_W-1:0]  w_wr_entry;
    logic [c_ENTRY_W-1:0]  w_rd_entry;

    // Both ready and valid derive from the registered count only, so neither
    // side of the FIFO forms a combinational path to the other.
    assign s_tready    = (r_count != c_FULL);
    assign m_tvalid    = (r_count != '0);
    assign w_push      = s_tvalid && s_tready;
    assign w_pop       = m_tvalid && m_tready;
    assign w_wr_entry  = {s_tlast, s_tdata};
    assign w_head_last = w_rd_entry[c_ENTRY_W-1];

    fir_fifo_ram #(
        .DEPTH  (pDEPTH),
        .WIDTH  (c_ENTRY_W),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk   (axis_clk),
        .we    (w_push),
        .waddr (r_wr_ptr),
        .wdata (w_wr_entry),
        .raddr (r_rd_ptr),
        .rdata (w_rd_entry)
    );

    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Clear wins over increment, but the frame_done pulse is still emitted.
    always_ff @(posedge axis_clk) begin
        if (!axis_rst_n) begin
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_frame_done <= w_pop && w_head_last;
            if (cnt_clr) begin
                r_frame_cnt <= '0;
            end else if (w_pop && w_head_last) begin
                r_frame_cnt <= r_frame_cnt + pCNT_WIDTH'(1);
            end
        end
    end

    assign m_tdata    = w_rd_entry[pDATA_WIDTH-1:0];
    assign m_tlast    = m_tvalid && w_head_last;
    assign level      = r_count;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fir_out_fifo.sv
// ============================================================================
//  Module   : tb_fir_out_fifo
//  Brief    : Scoreboard bench for fir_out_fifo with a frame-counter model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_out_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          axis_clk;
    logic          axis_rst_n;
    logic          s_tvalid;
    logic [DW-1:0] s_tdata;
    logic          s_tlast;
    logic          s_tready;
    logic          m_tvalid;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tready;
    logic [3:0]    level;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;
    logic          cnt_clr;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW:0]   sb_q[$];
    logic          exp_fd  = 1'b0;
    logic [CW-1:0] exp_cnt = '0;

    fir_out_fifo #(
        .pDATA_WIDTH (DW),
        .pDEPTH      (DEPTH),
        .pCNT_WIDTH  (CW)
    ) dut (
        .axis_clk   (axis_clk),
        .axis_rst_n (axis_rst_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .level      (level),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt),
        .cnt_clr    (cnt_clr)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after posedge, so at negedge they are stable
    // for the coming edge; the monitor judges that edge's handshakes here.
    always @(negedge axis_clk) begin
        check_eq("frame_done", frame_done, exp_fd);
        check_eq("frame_cnt", frame_cnt, exp_cnt);
        check_eq("m_tvalid", m_tvalid, sb_q.size() != 0);
        check_eq("s_tready", s_tready, sb_q.size() != DEPTH);
        check_eq("level", level, sb_q.size());
        if (!axis_rst_n) begin
            sb_q.delete();
            exp_fd  = 1'b0;
            exp_cnt = '0;
        end else begin
            exp_fd = 1'b0;
            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0) begin
                    check_eq("pop_on_empty_q", sb_q.size(), 1);
                end else begin
                    check_eq("pop_entry", {m_tlast, m_tdata}, sb_q[0]);
                    exp_fd = sb_q[0][DW];
                    void'(sb_q.pop_front());
                end
            end
            if (cnt_clr) exp_cnt = '0;
            else if (exp_fd) exp_cnt = exp_cnt + 16'd1;
            if (s_tvalid && s_tready) sb_q.push_back({s_tlast, s_tdata});
        end
    end

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic push_beat(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        @(negedge axis_clk);
        while (!s_tready && n < 200) begin
            @(negedge axis_clk);
            n++;
        end
        if (!s_tready) check_eq("push_timeout", s_tready, 1);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (m_tvalid && n < 200) begin
            tick();
            n++;
        end
        if (m_tvalid) check_eq("drain_timeout", m_tvalid, 0);
    endtask

    logic [DW-1:0] held_data;
    logic          held_last;

    initial begin
        axis_rst_n = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        cnt_clr    = 1'b0;
        tick();
        tick();
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check_eq("rst_s_tready", s_tready, 1);
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_m_tlast", m_tlast, 0);
        check_eq("rst_frame_done", frame_done, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_frame_cnt", frame_cnt, 0);
        tick();

        // Pass-through
        m_tready = 1'b1;
        push_beat(32'd1, 1'b0);
        push_beat(32'd2, 1'b0);
        push_beat(32'd3, 1'b1);
        wait_empty();
        tick();
        tick();
        check_eq("pt_frame_cnt", frame_cnt, 1);

        // Fill to full, then release
        m_tready = 1'b0;
        fork
            begin
                for (int i = 0; i < 10; i++) push_beat(32'h100 + i, i == 9);
            end
            begin
                repeat (12) tick();
                @(negedge axis_clk);
                check_eq("full_level", level, 8);
                check_eq("full_s_tready", s_tready, 0);
                tick();
                m_tready = 1'b1;
            end
        join
        wait_empty();
        tick();
        check_eq("fill_frame_cnt", frame_cnt, 2);

        // Stall stability
        m_tready = 1'b0;
        push_beat(32'hCAFE_0001, 1'b1);
        push_beat(32'hCAFE_0002, 1'b0);
        @(negedge axis_clk);
        held_data = m_tdata;
        held_last = m_tlast;
        check_eq("stall_head", {held_last, held_data}, {1'b1, 32'hCAFE_0001});
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge axis_clk);
            check_eq("stall_data", m_tdata, held_data);
            check_eq("stall_last", m_tlast, held_last);
            check_eq("stall_valid", m_tvalid, 1);
        end
        tick();
        m_tready = 1'b1;
        wait_empty();

        // Concurrent push/pop at level 4 across pointer wrap
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) push_beat(32'h200 + i, 1'b0);
        m_tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h300 + i;
            s_tlast  = (i % 5) == 4;
            @(negedge axis_clk);
            check_eq("conc_level", level, 4);
            tick();
        end
        s_tvalid = 1'b0;
        wait_empty();
        tick();
        check_eq("conc_frame_cnt", frame_cnt, 7);

        // Mid-frame reset
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) push_beat(32'h400 + i, i == 4);
        axis_rst_n = 1'b0;
        tick();
        axis_rst_n = 1'b1;
        @(negedge axis_clk);
        check_eq("mrst_m_tvalid", m_tvalid, 0);
        check_eq("mrst_level", level, 0);
        check_eq("mrst_frame_cnt", frame_cnt, 0);
        tick();
        m_tready = 1'b1;
        repeat (4) tick();

        // Clear coinciding with a tlast pop
        m_tready = 1'b0;
        push_beat(32'h500, 1'b1);
        m_tready = 1'b1;
        cnt_clr  = 1'b1;
        tick();
        m_tready = 1'b0;
        cnt_clr  = 1'b0;
        @(negedge axis_clk);
        check_eq("clr_frame_done", frame_done, 1);
        check_eq("clr_frame_cnt", frame_cnt, 0);
        tick();
        m_tready = 1'b1;
        push_beat(32'h600, 1'b0);
        push_beat(32'h601, 1'b1);
        wait_empty();
        tick();
        check_eq("clr_next_frame_cnt", frame_cnt, 1);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_out_fifo.md
# fir_out_fifo

Downstream buffering stage for the FIR engine's AXI-Stream output. It accepts filtered samples from the FIR `sm_*` master port and stores them, with their `tlast` flag, in a small circular FIFO. It presents them on a downstream AXI-Stream master, so consumer back-pressure does not stall the tap/data BRAM pipeline sample-by-sample. It also counts completed frames and pulses a flag at each frame end for the control/status logic.

## Interface
Parameters:
- pDATA_WIDTH, 32, sample width; matches FIR `sm_tdata`.
- pDEPTH, 8, FIFO entries; power of two, ≥ 2.
- pCNT_WIDTH, 16, frame counter width.

Ports:
- axis_clk  in  1  single clock for all logic.
- axis_rst_n  in  1  reset; synchronous, active-low.
- s_tvalid  in  1  upstream valid; driven by FIR `sm_tvalid`.
- s_tdata  in  pDATA_WIDTH  upstream sample.
- s_tlast  in  1  upstream end-of-frame marker.
- s_tready  out  1  FIFO can accept; drives FIR `sm_tready`.
- m_tvalid  out  1  downstream valid.
- m_tdata  out  pDATA_WIDTH  head-of-FIFO sample.
- m_tlast  out  1  head-of-FIFO last flag.
- m_tready  in  1  downstream ready.
- level  out  $clog2(pDEPTH)+1  current occupancy, 0..pDEPTH.
- frame_done  out  1  one-cycle pulse when a `tlast` beat leaves on m_*.
- frame_cnt  out  pCNT_WIDTH  completed frames since reset/clear.
- cnt_clr  in  1  synchronous clear of frame_cnt.

## Operation
- Storage: pDEPTH × (pDATA_WIDTH+1) register array holding {tlast, tdata}, with write pointer wr_ptr, read pointer rd_ptr and occupancy count.
- Push: on `s_tvalid && s_tready`, write the entry at wr_ptr and increment wr_ptr modulo pDEPTH.
- Pop: on `m_tvalid && m_tready`, increment rd_ptr modulo pDEPTH.
- s_tready = (count != pDEPTH). It is a function of registered count only and never depends on m_tready. When full, no write occurs, even if a pop happens in the same cycle.
- m_tvalid = (count != 0). m_tdata/m_tlast show the entry at rd_ptr (first-word fall-through). They hold stable while `m_tvalid && !m_tready`.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Empty: no pop, and the m_tdata value is don't-care.
- Full: s_tready is low and s_tvalid/s_tdata must be held by upstream.
- Pointer wrap: modulo pDEPTH with no gap; pointers are $clog2(pDEPTH) bits.
- frame_done is registered. It is 1 in the cycle after a pop whose entry had tlast=1.
- frame_cnt increments in the same edge that sets frame_done and wraps at 2^pCNT_WIDTH.
- cnt_clr has priority over the increment. If both occur in one cycle, frame_cnt becomes 0 and frame_done still pulses.
- level = count.
- No data transformation is applied, and tlast is preserved exactly per beat.

## Timing
- Reset (axis_rst_n low at a clock edge) sets wr_ptr=0, rd_ptr=0, count=0 and frame_cnt=0. Outputs then read s_tready=1, m_tvalid=0, m_tlast=0, frame_done=0, level=0.
- Reset mid-operation discards all stored entries, including any frame in flight, and no frame_done is emitted for them. The array contents themselves need no reset.
- Latency: a sample pushed at edge N is visible with m_tvalid=1 after edge N, so it can be popped at edge N+1 at the earliest.
- Throughput: one beat per cycle sustained when m_tready=1 and s_tvalid=1.
- s_tready rises the cycle after the pop that leaves the FIFO non-full (one-cycle bubble when full).
- AXI-Stream rules: m_tvalid never drops without a handshake, and m_tdata/m_tlast are stable while stalled.

## Structure
- Shared package fir_pkg: pDATA_WIDTH default and the `{tlast,data}` entry width constant. Share only what the FIR and this FIFO both consume.
- One natural sub-module: fir_fifo_ram, the parameterised register array with write port and asynchronous read port. Pointers, count, handshakes and the frame counter stay in fir_out_fifo.

## Test plan
- Pass-through: m_tready=1, push 1,2,3 (tlast on 3). The same values appear in order one cycle later, with frame_done pulsing once and frame_cnt=1.
- Fill/full: m_tready=0, push 10 beats with pDEPTH=8. s_tready drops after the 8th, level=8, and beats 9–10 are held off. Releasing m_tready drains 8 values in order, after which beats 9–10 are accepted.
- Stall stability: hold m_tready=0 with the FIFO non-empty for 5 cycles. m_tdata/m_tlast remain unchanged and m_tvalid stays 1.
- Concurrent push/pop at level 4 for 20 cycles: level stays 4, output order is correct, and pointers wrap past 7→0 without loss.
- Mid-frame reset: push 5 beats and assert axis_rst_n=0 for one edge. The outputs then read m_tvalid=0, level=0, frame_cnt=0, and no stale data appears afterwards.
- cnt_clr in the same cycle as a tlast pop: frame_cnt=0 and frame_done=1 the next cycle. A subsequent frame brings frame_cnt to 1.
